mux_tree_pipe: RTL and testbench
================================

Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 data multiplexer built as a tree of 2:1 select levels, with one register stage per level.
- Generalises the combinational 8:1 tree: configurable channel count and data width, valid/ready flow control, and select bits carried down the pipeline alongside the data.
- Used wherever a wide channel select must close timing at high clock rates.

Parameters:
- WIDTH, 8, data bits per input channel.
- N_IN, 8, number of input channels; any integer >= 2. Not restricted to powers of two.
- SEL_W, $clog2(N_IN), select width and number of tree levels. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_IN*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
- in_sel  input  SEL_W  channel index, sampled with in_data.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts an input this cycle.
- out_data  output  WIDTH  selected channel.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_err  output  1  present only with MUX_RANGE_CHK_EN; see Optional Feature.

Behaviour:
- Tree structure
  - Pad the channel vector to 2**SEL_W leaves; padded leaves are all-zero.
  - Level k (k = 0..SEL_W-1) resolves select bit k, LSB first.
  - Pair (2j, 2j+1) selects leaf 2j+1 when the bit is 1, else leaf 2j.
  - Level k registers 2**(SEL_W-1-k) partial results, the unused upper select bits [SEL_W-1:k+1], and a valid bit.
- Latency: exactly SEL_W cycles from an accepted input to out_valid, when not stalled.
  - For N_IN = 2, latency is 1.
- Flow control
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - An input is accepted when in_valid && in_ready.
  - When adv = 1, every stage loads from its predecessor; stage 0 loads valid = in_valid.
  - When adv = 0, all stages hold, including data, select and valid.
- Bubbles are not squeezed out: an invalid slot still takes a stage. Throughput is 1 per cycle when out_ready stays high.
- out_data/out_valid/out_err are driven directly by the last stage's registers; there is no combinational path from inputs to outputs.
- Reset values
  - All valid bits 0; all data and select registers 0.
  - out_valid = 0, out_data = 0, out_err = 0.
  - in_ready = 1 after reset, because out_valid = 0.
- Reset mid-operation: all in-flight items are discarded immediately (asynchronous). No output is produced for them after rst deasserts.
- Out-of-range select (in_sel >= N_IN, only possible for non-power-of-two N_IN): out_data = 0 via the zero padding, out_valid still asserted.
- Backpressure boundary: while out_valid = 1 and out_ready = 0, out_data must stay stable and in_ready = 0.
- Simultaneous out_ready rise and in_valid: the output transfers and a new input is accepted in the same cycle.

Optional Feature:
- Macro: MUX_RANGE_CHK_EN.
- With the macro defined:
  - out_err port exists.
  - A 1-bit flag (in_sel >= N_IN) is computed at stage 0 and pipelined with its item.
  - out_err is valid only when out_valid = 1 and is 0 otherwise.
- Without the macro: no out_err port, no flag logic; out-of-range selects simply yield zero data.

Decomposition:
- Package mux_tree_pkg:
  - Function clog2_min1(n) returning max(1, $clog2(n)).
  - Localparam helper for leaf count 2**SEL_W.
- Sub-module mux2_level:
  - Parameters WIDTH and PAIRS.
  - One registered level of 2:1 muxes with enable, async reset and a passthrough select/valid field.
- mux_tree_pipe instantiates SEL_W mux2_level copies in a generate loop.

Test Plan:
- Reset release, N_IN=8, WIDTH=8 -> out_valid=0, out_data=0x00, in_ready=1.
- Channels 0x10..0x17, in_sel=5, single in_valid pulse, out_ready=1 -> exactly 3 cycles later out_valid=1 for one cycle, out_data=0x15.
- Streaming: in_sel = 0,1,...,7 on consecutive cycles, out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles starting at cycle 3.
- Backpressure: in_sel=2 then 6 back to back, out_ready=0 when the first item reaches the output -> out_data held at 0x12 and in_ready=0 until out_ready=1, then 0x16 the next cycle, no loss or duplication.
- N_IN=5, in_sel=6 with MUX_RANGE_CHK_EN -> out_data=0, out_err=1; in_sel=4 -> data of channel 4, out_err=0.
- Assert rst for 1 cycle while 3 items are in flight -> outputs clear immediately, no out_valid for those items afterwards, in_ready=1.

Source files
------------

// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: level count and padded leaf count.
package mux_tree_pkg;

  // A 2-input tree still needs one level, so never return fewer than 1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int leaf_count(input int n);
    return 1 << clog2_min1(n);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_mux2_level.sv
// One registered level of 2:1 muxes; consumes sel[0] and passes the remaining
// select bits, valid and range-error flag down alongside the data.
module mux2_level #(
  parameter int WIDTH  = 8,
  parameter int PAIRS  = 1,
  parameter int SW     = 1,
  parameter bit ERR_EN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2*PAIRS*WIDTH-1:0] d,
  input  logic [SW-1:0]            sel,
  input  logic                     v,
  input  logic                     x,
  output logic [PAIRS*WIDTH-1:0]   q,
  output logic [SW-1:0]            sel_q,
  output logic                     v_q,
  output logic                     x_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      sel_q <= '0;
      v_q   <= 1'b0;
    end else if (en) begin
      for (int j = 0; j < PAIRS; j++) begin
        q[j*WIDTH +: WIDTH] <= sel[0] ? d[(2*j+1)*WIDTH +: WIDTH]
                                      : d[(2*j)*WIDTH +: WIDTH];
      end
      sel_q <= sel >> 1;
      v_q   <= v;
    end
  end

  generate
    if (ERR_EN) begin : g_err
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     x_q <= 1'b0;
        else if (en) x_q <= x;
      end
    end else begin : g_no_err
      logic unused_x;
      assign unused_x = x;
      assign x_q      = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one register per select level, global stall.
// Optional range-error flag on out_err when MUX_RANGE_CHK_EN is defined.
//
// Handshake: a transfer happens on a port when valid && ready at a rising
// clk edge. in_ready = !out_valid || out_ready; every stage advances together.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  N_IN  = 8,
  localparam int SEL_W = clog2_min1(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
`ifdef MUX_RANGE_CHK_EN
  output logic                  out_err,
`endif
  input  logic                  out_ready
);

  localparam int LEAVES = leaf_count(N_IN);
`ifdef MUX_RANGE_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [SEL_W:0][LEAVES*WIDTH-1:0] dat;
  logic [SEL_W:0][SEL_W-1:0]        sel_c;
  logic [SEL_W:0]                   v_c;
  logic [SEL_W:0]                   x_c;
  logic                             adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Zero extension pads the unused leaves so out-of-range selects yield 0.
  assign dat[0]   = (LEAVES*WIDTH)'(in_data);
  assign sel_c[0] = in_sel;
  assign v_c[0]   = in_valid;

`ifdef MUX_RANGE_CHK_EN
  localparam logic [SEL_W:0] N_IN_W = N_IN[SEL_W:0];
  assign x_c[0]  = in_valid && ({1'b0, in_sel} >= N_IN_W);
  assign out_err = x_c[SEL_W];
`else
  assign x_c[0] = 1'b0;
`endif

  generate
    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
      localparam int PAIRS = LEAVES >> (k + 1);
      logic [PAIRS*WIDTH-1:0] q_k;

      mux2_level #(
        .WIDTH (WIDTH),
        .PAIRS (PAIRS),
        .SW    (SEL_W),
        .ERR_EN(ERR_EN)
      ) u_lvl (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .d    (dat[k][2*PAIRS*WIDTH-1:0]),
        .sel  (sel_c[k]),
        .v    (v_c[k]),
        .x    (x_c[k]),
        .q    (q_k),
        .sel_q(sel_c[k+1]),
        .v_q  (v_c[k+1]),
        .x_q  (x_c[k+1])
      );

      assign dat[k+1] = (LEAVES*WIDTH)'(q_k);
    end
  endgenerate

  assign out_data  = dat[SEL_W][WIDTH-1:0];
  assign out_valid = v_c[SEL_W];

  // Upper tree bits and the final leftover select field are intentionally dropped.
  logic unused_ok;
  assign unused_ok = &{1'b0, dat, sel_c, x_c};

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: an 8-channel and a 5-channel instance share control
// inputs; a latency/stall queue model is compared every cycle.
module tb_mux_tree_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data8;
  logic [39:0] in_data5;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready8, in_ready5;
  logic [7:0]  out_data8, out_data5;
  logic        out_valid8, out_valid5;
  logic        out_err5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_tree_pipe #(.WIDTH(8), .N_IN(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready8), .out_data(out_data8),
    .out_valid(out_valid8),
`ifdef MUX_RANGE_CHK_EN
    .out_err(),
`endif
    .out_ready(out_ready)
  );

  mux_tree_pipe #(.WIDTH(8), .N_IN(5)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready5), .out_data(out_data5),
    .out_valid(out_valid5),
`ifdef MUX_RANGE_CHK_EN
    .out_err(out_err5),
`endif
    .out_ready(out_ready)
  );

`ifndef MUX_RANGE_CHK_EN
  assign out_err5 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: 3-deep slot queue, front = output. Entry {valid, err5, data5, data8}.
  logic [17:0] exp_q[$];
  logic [17:0] e_new;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(18'h0);
    end else if (exp_q.size() == 3 && (!exp_q[0][17] || out_ready)) begin
      e_new[17]   = in_valid;
      e_new[16]   = in_valid && (in_sel >= 3'd5);
      e_new[15:8] = (in_sel < 3'd5) ? 8'h20 + 8'(in_sel) : 8'h00;
      e_new[7:0]  = 8'h10 + 8'(in_sel);
      void'(exp_q.pop_front());
      exp_q.push_back(e_new);
    end
  end

  always @(negedge clk) begin
    if (!rst && exp_q.size() == 3) begin
      chk("m_valid8", 32'(out_valid8), 32'(exp_q[0][17]));
      chk("m_valid5", 32'(out_valid5), 32'(exp_q[0][17]));
      chk("m_ready8", 32'(in_ready8), 32'(!exp_q[0][17] || out_ready));
      chk("m_ready5", 32'(in_ready5), 32'(!exp_q[0][17] || out_ready));
      if (exp_q[0][17]) begin
        chk("m_data8", 32'(out_data8), 32'(exp_q[0][7:0]));
        chk("m_data5", 32'(out_data5), 32'(exp_q[0][15:8]));
      end
`ifdef MUX_RANGE_CHK_EN
      chk("m_err5", 32'(out_err5), 32'(exp_q[0][16]));
`endif
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h20 + 8'(i);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid8), 32'h0);
    chk("rst_data", 32'(out_data8), 32'h00);
    chk("rst_ready", 32'(in_ready8), 32'h1);
    chk("rst_err", 32'(out_err5), 32'h0);

    // Single item, sel=5, latency 3
    in_valid = 1'b1; in_sel = 3'd5;
    step();
    in_valid = 1'b0;
    chk("lat_c1", 32'(out_valid8), 32'h0);
    step();
    chk("lat_c2", 32'(out_valid8), 32'h0);
    step();
    chk("lat_c3_v", 32'(out_valid8), 32'h1);
    chk("lat_c3_d", 32'(out_data8), 32'h15);
    chk("lat_c3_d5", 32'(out_data5), 32'h00);
    step();
    chk("lat_c4", 32'(out_valid8), 32'h0);

    // Streaming 0..7
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i);
      step();
      if (i >= 2) begin
        chk("stream_v", 32'(out_valid8), 32'h1);
        chk("stream_d", 32'(out_data8), 32'h10 + 32'(i - 2));
      end else begin
        chk("stream_pre", 32'(out_valid8), 32'h0);
      end
    end
    in_valid = 1'b0;
    step();
    chk("stream_d6", 32'(out_data8), 32'h16);
    step();
    chk("stream_d7", 32'(out_data8), 32'h17);
    step();
    chk("stream_end", 32'(out_valid8), 32'h0);

    // Backpressure: 2 then 6, stall at output, release with a new input
    in_valid = 1'b1; in_sel = 3'd2;
    step();
    in_sel = 3'd6;
    step();
    in_valid = 1'b0;
    step();
    chk("bp_first", 32'(out_data8), 32'h12);
    out_ready = 1'b0;
    #1;
    chk("bp_rdy0", 32'(in_ready8), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_v", 32'(out_valid8), 32'h1);
      chk("bp_hold_d", 32'(out_data8), 32'h12);
      chk("bp_hold_r", 32'(in_ready8), 32'h0);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd3;
    #1;
    chk("bp_rdy1", 32'(in_ready8), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_second", 32'(out_data8), 32'h16);
    step();
    chk("bp_bubble", 32'(out_valid8), 32'h0);
    step();
    chk("bp_same_cyc", 32'(out_data8), 32'h13);
    step();
    chk("bp_end", 32'(out_valid8), 32'h0);

    // Non-power-of-two: sel 6 out of range, sel 4 in range
    in_valid = 1'b1; in_sel = 3'd6;
    step();
    in_sel = 3'd4;
    step();
    in_valid = 1'b0;
    step();
    chk("n5_oor_v", 32'(out_valid5), 32'h1);
    chk("n5_oor_d", 32'(out_data5), 32'h00);
    chk("n5_oor_d8", 32'(out_data8), 32'h16);
`ifdef MUX_RANGE_CHK_EN
    chk("n5_oor_err", 32'(out_err5), 32'h1);
`endif
    step();
    chk("n5_in_d", 32'(out_data5), 32'h24);
    chk("n5_in_d8", 32'(out_data8), 32'h14);
    chk("n5_in_err", 32'(out_err5), 32'h0);
    step();
    chk("n5_end", 32'(out_valid5), 32'h0);

    // Reset with 3 items in flight
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_sel = 3'(i);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_v", 32'(out_valid8), 32'h0);
    chk("mid_rst_d", 32'(out_data8), 32'h00);
    chk("mid_rst_r", 32'(in_ready8), 32'h1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_v", 32'(out_valid8), 32'h0);
      chk("post_rst_v5", 32'(out_valid5), 32'h0);
    end

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("drain_v", 32'(out_valid8), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
